// File: rtl/ascon_decrypt_fsm.sv
// Control sequencer for the ASCON-128 decryption datapath: drives round index,
// mux selects, write enables and XOR enables, and handshakes blocks upstream.
module ascon_decrypt_fsm #(
  parameter int unsigned NB_AD_BLOCKS = 1,
  parameter int unsigned NB_CT_BLOCKS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       plaintext_valid_o,
  output logic       sel_mux_perm_o,
  output logic       sel_muxData_perm_o,
  output logic [3:0] round_o,
  output logic       write_enable_data_o,
  output logic       write_enable_cipher_o,
  output logic       write_enable_tag_o,
  output logic       en_xor_begin_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_end_lsb_o,
  output logic       en_xor_end_key_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(NB_AD_BLOCKS - 1);
  localparam logic [CNT_W-1:0] CT_LAST    = CNT_W'(NB_CT_BLOCKS - 1);
  localparam logic [CNT_W-1:0] RND_FIRST  = CNT_W'(0);
  localparam logic [CNT_W-1:0] RND_HALF   = CNT_W'(6);
  localparam logic [CNT_W-1:0] RND_LAST   = CNT_W'(11);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_CT, S_CT, S_FINAL, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_round;
  logic [CNT_W-1:0] r_ad_cnt;
  logic [CNT_W-1:0] r_ct_cnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_round_nxt;
  logic [CNT_W-1:0] w_ad_nxt;
  logic [CNT_W-1:0] w_ct_nxt;
  logic             w_data_req;
  logic             w_busy;
  logic             w_done;
  logic             w_sel_perm;
  logic             w_sel_data;
  logic             w_we_data;
  logic             w_we_cipher;
  logic             w_we_tag;
  logic             w_xor_begin_data;
  logic             w_xor_begin_key;
  logic             w_xor_end_lsb;
  logic             w_xor_end_key;

  // Next state/counters, then outputs decoded from the next values so they register in step with the state.
  always_comb begin
    w_state_nxt      = r_state;
    w_round_nxt      = r_round;
    w_ad_nxt         = r_ad_cnt;
    w_ct_nxt         = r_ct_cnt;
    w_data_req       = 1'b0;
    w_busy           = 1'b0;
    w_done           = 1'b0;
    w_sel_perm       = 1'b0;
    w_sel_data       = 1'b0;
    w_we_data        = 1'b0;
    w_we_cipher      = 1'b0;
    w_we_tag         = 1'b0;
    w_xor_begin_data = 1'b0;
    w_xor_begin_key  = 1'b0;
    w_xor_end_lsb    = 1'b0;
    w_xor_end_key    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_INIT;
          w_round_nxt = RND_FIRST;
          w_ad_nxt    = '0;
          w_ct_nxt    = '0;
        end
      end
      S_INIT: begin
        if (r_round == RND_LAST) begin
          w_state_nxt = S_WAIT_AD;
          w_round_nxt = RND_HALF;
        end else begin
          w_round_nxt = r_round + CNT_W'(1);
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) w_state_nxt = S_AD;
      end
      S_AD: begin
        if (r_round == RND_LAST) begin
          w_ad_nxt    = r_ad_cnt + CNT_W'(1);
          w_round_nxt = RND_HALF;
          w_state_nxt = (r_ad_cnt == AD_LAST) ? S_WAIT_CT : S_WAIT_AD;
        end else begin
          w_round_nxt = r_round + CNT_W'(1);
        end
      end
      S_WAIT_CT: begin
        if (data_valid_i) begin
          if (r_ct_cnt == CT_LAST) begin
            w_state_nxt = S_FINAL;
            w_round_nxt = RND_FIRST;
          end else begin
            w_state_nxt = S_CT;
            w_round_nxt = RND_HALF;
          end
        end
      end
      S_CT: begin
        if (r_round == RND_LAST) begin
          w_ct_nxt    = r_ct_cnt + CNT_W'(1);
          w_round_nxt = RND_HALF;
          w_state_nxt = S_WAIT_CT;
        end else begin
          w_round_nxt = r_round + CNT_W'(1);
        end
      end
      S_FINAL: begin
        if (r_round == RND_LAST) begin
          w_state_nxt = S_DONE;
          w_round_nxt = RND_FIRST;
        end else begin
          w_round_nxt = r_round + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = RND_FIRST;
        w_ad_nxt    = '0;
        w_ct_nxt    = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = RND_FIRST;
        w_ad_nxt    = '0;
        w_ct_nxt    = '0;
      end
    endcase

    w_busy     = (w_state_nxt != S_IDLE);
    w_done     = (w_state_nxt == S_DONE);
    w_data_req = (w_state_nxt == S_WAIT_AD) || (w_state_nxt == S_WAIT_CT);
    w_we_data  = (w_state_nxt == S_INIT) || (w_state_nxt == S_AD) ||
                 (w_state_nxt == S_CT)   || (w_state_nxt == S_FINAL);
    w_sel_perm = ((w_state_nxt == S_INIT) && (w_round_nxt != RND_FIRST)) ||
                 (w_state_nxt == S_AD) || (w_state_nxt == S_CT) || (w_state_nxt == S_FINAL);
    w_sel_data = (w_state_nxt == S_CT) || (w_state_nxt == S_FINAL);
    w_we_cipher = ((w_state_nxt == S_CT) && (w_round_nxt == RND_HALF)) ||
                  ((w_state_nxt == S_FINAL) && (w_round_nxt == RND_FIRST));
    w_we_tag   = (w_state_nxt == S_FINAL) && (w_round_nxt == RND_LAST);
    w_xor_begin_data = (((w_state_nxt == S_AD) || (w_state_nxt == S_CT)) && (w_round_nxt == RND_HALF)) ||
                       ((w_state_nxt == S_FINAL) && (w_round_nxt == RND_FIRST));
    w_xor_begin_key  = (w_state_nxt == S_FINAL) && (w_round_nxt == RND_FIRST);
    w_xor_end_lsb    = (w_state_nxt == S_AD) && (w_round_nxt == RND_LAST) && (w_ad_nxt == AD_LAST);
    w_xor_end_key    = ((w_state_nxt == S_INIT) || (w_state_nxt == S_FINAL)) && (w_round_nxt == RND_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state               <= S_IDLE;
      r_round               <= '0;
      r_ad_cnt              <= '0;
      r_ct_cnt              <= '0;
      data_req_o            <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      plaintext_valid_o     <= 1'b0;
      sel_mux_perm_o        <= 1'b0;
      sel_muxData_perm_o    <= 1'b0;
      write_enable_data_o   <= 1'b0;
      write_enable_cipher_o <= 1'b0;
      write_enable_tag_o    <= 1'b0;
      en_xor_begin_data_o   <= 1'b0;
      en_xor_begin_key_o    <= 1'b0;
      en_xor_end_lsb_o      <= 1'b0;
      en_xor_end_key_o      <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_round               <= w_round_nxt;
      r_ad_cnt              <= w_ad_nxt;
      r_ct_cnt              <= w_ct_nxt;
      data_req_o            <= w_data_req;
      busy_o                <= w_busy;
      done_o                <= w_done;
      plaintext_valid_o     <= write_enable_cipher_o;
      sel_mux_perm_o        <= w_sel_perm;
      sel_muxData_perm_o    <= w_sel_data;
      write_enable_data_o   <= w_we_data;
      write_enable_cipher_o <= w_we_cipher;
      write_enable_tag_o    <= w_we_tag;
      en_xor_begin_data_o   <= w_xor_begin_data;
      en_xor_begin_key_o    <= w_xor_begin_key;
      en_xor_end_lsb_o      <= w_xor_end_lsb;
      en_xor_end_key_o      <= w_xor_end_key;
    end
  end

  assign round_o = r_round;

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// Bench for ascon_decrypt_fsm: a phase-level trace model (default and 2-AD/1-CT
// configurations) with random stalls and stray start/valid, plus latency and reset checks.
module tb_ascon_decrypt_fsm;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic valid;
  logic sel;
  logic start0, start1;
  always #5 clk = ~clk;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  // Observed vector layout: req,busy,done,pv,selm,seld,round[3:0],wed,wec,wet,xbd,xbk,xel,xek
  logic a_req, a_busy, a_done, a_pv, a_sm, a_sd, a_wd, a_wc, a_wt, a_xbd, a_xbk, a_xel, a_xek;
  logic b_req, b_busy, b_done, b_pv, b_sm, b_sd, b_wd, b_wc, b_wt, b_xbd, b_xbk, b_xel, b_xek;
  logic [3:0] a_rnd, b_rnd;
  logic [16:0] obs0, obs1, obs;
  assign obs0 = {a_req, a_busy, a_done, a_pv, a_sm, a_sd, a_rnd, a_wd, a_wc, a_wt, a_xbd, a_xbk, a_xel, a_xek};
  assign obs1 = {b_req, b_busy, b_done, b_pv, b_sm, b_sd, b_rnd, b_wd, b_wc, b_wt, b_xbd, b_xbk, b_xel, b_xek};
  assign obs  = sel ? obs1 : obs0;

  ascon_decrypt_fsm #(.NB_AD_BLOCKS(1), .NB_CT_BLOCKS(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .data_valid_i(valid),
    .data_req_o(a_req), .busy_o(a_busy), .done_o(a_done), .plaintext_valid_o(a_pv),
    .sel_mux_perm_o(a_sm), .sel_muxData_perm_o(a_sd), .round_o(a_rnd),
    .write_enable_data_o(a_wd), .write_enable_cipher_o(a_wc), .write_enable_tag_o(a_wt),
    .en_xor_begin_data_o(a_xbd), .en_xor_begin_key_o(a_xbk),
    .en_xor_end_lsb_o(a_xel), .en_xor_end_key_o(a_xek));

  ascon_decrypt_fsm #(.NB_AD_BLOCKS(2), .NB_CT_BLOCKS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .data_valid_i(valid),
    .data_req_o(b_req), .busy_o(b_busy), .done_o(b_done), .plaintext_valid_o(b_pv),
    .sel_mux_perm_o(b_sm), .sel_muxData_perm_o(b_sd), .round_o(b_rnd),
    .write_enable_data_o(b_wd), .write_enable_cipher_o(b_wc), .write_enable_tag_o(b_wt),
    .en_xor_begin_data_o(b_xbd), .en_xor_begin_key_o(b_xbk),
    .en_xor_end_lsb_o(b_xel), .en_xor_end_key_o(b_xek));

  localparam logic [16:0] M_ALL  = 17'h1FFFF;
  localparam logic [16:0] M_INIT = 17'h1F7FF;   // sel_muxData free during INIT
  localparam logic [16:0] M_WAIT = 17'h1E07F;   // selects and round free while stalled/done

  int total = 0;
  int bad   = 0;

  logic [16:0] q_exp[$];
  logic [16:0] q_msk[$];
  bit          q_val[$];
  bit          q_st[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic void push(bit req, bit bsy, bit dn, bit sm, bit sd, int rnd, bit wd,
                               bit wc, bit wt, bit xbd, bit xbk, bit xel, bit xek,
                               logic [16:0] m, bit v, bit st);
    q_exp.push_back({req, bsy, dn, 1'b0, sm, sd, 4'(rnd), wd, wc, wt, xbd, xbk, xel, xek});
    q_msk.push_back(m);
    q_val.push_back(v);
    q_st.push_back(st);
  endfunction

  // One handshake wait: 'stall' cycles without data, then one cycle with data offered.
  function automatic void wait_phase(int stall);
    for (int k = 0; k < stall; k++)
      push(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_WAIT, 1'b0, 1'($urandom));
    push(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_WAIT, 1'b1, 1'($urandom));
  endfunction

  // Cycle-by-cycle expectation of one run built from the phase sequence.
  function automatic void build(int nad, int nct, int maxst, int fidx, int flen);
    int w = 0;
    q_exp.delete(); q_msk.delete(); q_val.delete(); q_st.delete();
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 1'($urandom), 1'b1);
    for (int r = 0; r < 12; r++)
      push(0, 1, 0, r != 0, 0, r, 1, 0, 0, 0, 0, 0, r == 11, M_INIT, 1'($urandom), 1'($urandom));
    for (int a = 0; a < nad; a++) begin
      wait_phase(w == fidx ? flen : int'($urandom_range(maxst, 0)));
      w++;
      for (int r = 6; r < 12; r++)
        push(0, 1, 0, 1, 0, r, 1, 0, 0, r == 6, 0, (r == 11) && (a == nad - 1), 0,
             M_ALL, 1'($urandom), 1'($urandom));
    end
    for (int c = 0; c < nct - 1; c++) begin
      wait_phase(w == fidx ? flen : int'($urandom_range(maxst, 0)));
      w++;
      for (int r = 6; r < 12; r++)
        push(0, 1, 0, 1, 1, r, 1, r == 6, 0, r == 6, 0, 0, 0, M_ALL, 1'($urandom), 1'($urandom));
    end
    wait_phase(w == fidx ? flen : int'($urandom_range(maxst, 0)));
    for (int r = 0; r < 12; r++)
      push(0, 1, 0, 1, 1, r, 1, r == 0, r == 11, r == 0, r == 0, 0, r == 11,
           M_ALL, 1'($urandom), 1'($urandom));
    push(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_WAIT, 1'($urandom), 1'b1);
    for (int i = 1; i < q_exp.size(); i++) q_exp[i][13] = q_exp[i-1][5];
  endfunction

  // Plays one run; cycle 0 is the start-sampling cycle. abort_at asserts reset mid-cycle.
  task automatic run(input bit s, input int maxst, input int fidx, input int flen,
                     input int abort_at, output int done_at, output int pv_cnt, output int tag_at);
    build(s ? 2 : 1, s ? 1 : 4, maxst, fidx, flen);
    sel = s;
    done_at = -1; pv_cnt = 0; tag_at = -1;
    for (int i = 0; i < q_exp.size(); i++) begin
      start = q_st[i];
      valid = q_val[i];
      @(negedge clk);
      chk($sformatf("trace[%0d]", i), 32'(obs & q_msk[i]), 32'(q_exp[i] & q_msk[i]));
      if (obs[14] && done_at < 0) done_at = i;
      if (obs[13]) pv_cnt++;
      if (obs[4]) tag_at = i;
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'(obs), 32'd0);
        start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_outputs", 32'(obs), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, t;
    rst = 1'b1; start = 1'b0; valid = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut0", 32'(obs0), 32'd0);
    chk("reset_dut1", 32'(obs1), 32'd0);
    rst = 1'b0;
    idle(2);

    run(1'b0, 0, -1, 0, -1, d, p, t);
    chk("latency_default", 32'(d), 32'd54);
    chk("pv_count_default", 32'(p), 32'd4);
    chk("tag_before_done", 32'(t), 32'd53);

    // back-to-back with start held through DONE, 10-cycle stall before the last CT wait
    run(1'b0, 0, 3, 10, -1, d, p, t);
    chk("latency_stall10", 32'(d), 32'd64);
    chk("pv_count_stall", 32'(p), 32'd4);
    idle(2);

    // reset mid-AD at round 8 (trace index 16), then a clean restart
    run(1'b0, 0, -1, 0, 16, d, p, t);
    idle(2);
    run(1'b0, 0, -1, 0, -1, d, p, t);
    chk("latency_after_reset", 32'(d), 32'd54);
    idle(1);

    run(1'b1, 0, -1, 0, -1, d, p, t);
    chk("latency_ad2_ct1", 32'(d), 32'd40);
    chk("pv_count_ad2_ct1", 32'(p), 32'd1);
    chk("tag_ad2_ct1", 32'(t), 32'd39);

    for (int k = 0; k < 6; k++) begin
      bit s;
      s = 1'($urandom);
      run(s, 3, -1, 0, -1, d, p, t);
      chk($sformatf("pv_count_rand%0d", k), 32'(p), s ? 32'd1 : 32'd4);
      chk($sformatf("tag_rand%0d", k), 32'(t), 32'(d - 1));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_decrypt_fsm.md
Name: ascon_decrypt_fsm

Overview:
Control FSM for the fixed-configuration ASCON-128 decryption datapath `permutationBloc_decrypt`. It sequences initialisation, associated-data absorption, ciphertext decryption and finalisation by driving every select, round, write-enable and XOR-enable input of that datapath. It also runs a simple block-level handshake with the upstream data source. It sits directly upstream of the permutation datapath.

Parameters:
NB_AD_BLOCKS, 1, number of 64-bit associated-data blocks; legal range 1..15.
NB_CT_BLOCKS, 4, number of 64-bit ciphertext blocks, last one included; legal range 1..15.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-high.
start_i  in  1  starts one decryption; sampled only in IDLE.
data_valid_i  in  1  next AD/CT block present on the datapath inputs.
data_req_o  out  1  FSM waiting for the next block.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse; the tag is valid.
plaintext_valid_o  out  1  one-cycle pulse, one cycle after each write_enable_cipher_o.
sel_mux_perm_o  out  1  0 = load the external initial state, 1 = feed back the internal state.
sel_muxData_perm_o  out  1  0 = AD absorption (XOR), 1 = ciphertext mode.
round_o  out  4  permutation round constant index, 0..11.
write_enable_data_o  out  1  state register enable.
write_enable_cipher_o  out  1  plaintext output register enable.
write_enable_tag_o  out  1  tag register enable.
en_xor_begin_data_o  out  1  XOR data into the rate before the round.
en_xor_begin_key_o  out  1  XOR the key before the round (finalisation).
en_xor_end_lsb_o  out  1  XOR domain-separation bit after the round.
en_xor_end_key_o  out  1  XOR the key after the round.

Behaviour:
- Moore FSM with registered outputs. Counters:
  - round counter, 4 bits;
  - AD block counter, 4 bits;
  - CT block counter, 4 bits.
- On reset (asynchronous, any state): state = IDLE, all counters = 0, every output = 0.
- IDLE: all outputs 0. When start_i = 1, go to INIT; the first INIT cycle is the next cycle. start_i is ignored in all other states.
- INIT: 12 cycles, round_o = 0..11.
  - Cycle with round 0: sel_mux_perm_o = 0. Rounds 1..11: sel_mux_perm_o = 1.
  - write_enable_data_o = 1 throughout.
  - Round 11: en_xor_end_key_o = 1.
  - Then go to WAIT_AD.
- WAIT_AD / WAIT_CT:
  - data_req_o = 1, write_enable_data_o = 0 (state register holds), all XOR enables = 0.
  - Minimum 1 cycle, even if data_valid_i is already high.
  - When data_valid_i = 1, go to AD / CT respectively.
- AD: 6 cycles, round_o = 6..11, sel_mux_perm_o = 1, sel_muxData_perm_o = 0, write_enable_data_o = 1.
  - First cycle: en_xor_begin_data_o = 1.
  - Last cycle of the final AD block (counter = NB_AD_BLOCKS-1): en_xor_end_lsb_o = 1.
  - After round 11: increment the AD counter. Go to WAIT_AD if blocks remain, else WAIT_CT.
- CT, non-final block (counter < NB_CT_BLOCKS-1): 6 cycles, rounds 6..11, sel_muxData_perm_o = 1.
  - First cycle: en_xor_begin_data_o = 1 and write_enable_cipher_o = 1.
  - After round 11: increment the CT counter, go to WAIT_CT.
- FINAL (reached from WAIT_CT when counter = NB_CT_BLOCKS-1): 12 cycles, rounds 0..11, sel_mux_perm_o = 1, sel_muxData_perm_o = 1.
  - Round 0: en_xor_begin_data_o = 1, en_xor_begin_key_o = 1, write_enable_cipher_o = 1.
  - Round 11: en_xor_end_key_o = 1, write_enable_tag_o = 1.
  - Then go to DONE.
- DONE: 1 cycle, done_o = 1, busy_o = 1, then IDLE.
- Timing and counter rules:
  - plaintext_valid_o is write_enable_cipher_o delayed one cycle, so it asserts exactly NB_CT_BLOCKS times per run.
  - Round counter wraps 11→0 or 11→6 according to the next state; values 12..15 never appear.
  - The datapath state is unchanged across any number of WAIT cycles.
- Minimum latency from the start_i sampling edge to done_o (valid held high): 12 + 7·NB_AD_BLOCKS + 7·(NB_CT_BLOCKS-1) + 13 + 1 cycles. With defaults this is 54.

Test Plan:
- Reset, then start_i = 1 for one cycle → over the next 12 cycles round_o = 0,1,…,11 with sel_mux_perm_o = 0 only at round 0; en_xor_end_key_o = 1 only at round 11; then data_req_o = 1.
- Defaults with data_valid_i tied 1 → done_o pulses exactly 54 cycles after the start edge; plaintext_valid_o pulses 4 times; en_xor_end_lsb_o pulses once (AD round 11); write_enable_tag_o pulses once, one cycle before done_o.
- Hold data_valid_i = 0 for 10 cycles in WAIT_CT after CT block 1 → data_req_o = 1 and write_enable_data_o = 0 for all 10 cycles; sequence resumes with round_o = 6 one cycle after data_valid_i rises; done_o arrives 10 cycles later than the no-stall run (64).
- Assert rst_i asynchronously mid-AD at round_o = 8 → all outputs 0 immediately, without waiting for a clock edge; a following start_i restarts from INIT round 0 and completes normally in 54 cycles.
- start_i pulsed during busy (INIT and CT) → ignored; exactly one done_o per run. start_i held high through DONE → a new run begins with INIT immediately after IDLE.
- NB_AD_BLOCKS = 2, NB_CT_BLOCKS = 1 → two AD passes (en_xor_end_lsb_o only on the second), FINAL follows the first WAIT_CT; done_o at 12+14+0+14 = 40 cycles.
